// File: rtl/cpu_pkg.sv
// Shared CPU core definitions: register file geometry and common types.
package cpu_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned REG_DATA_W = 32;

   localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = '0;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Per-register busy scoreboard with registered busy population count.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   clr_a/clr_a_addr        clear request from write port A
//   clr_b/clr_b_addr        clear request from write port B
//   set/set_addr            set request from issue
//   flush                   clear every busy bit (overrides set/clear)
//   busy                    registered busy vector
//   busy_cnt                registered count of set busy bits
module regfile_sb_scoreboard
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W = REG_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr_a,
   input  logic [ADDR_W-1:0]     clr_a_addr,
   input  logic                  clr_b,
   input  logic [ADDR_W-1:0]     clr_b_addr,
   input  logic                  set,
   input  logic [ADDR_W-1:0]     set_addr,
   input  logic                  flush,
   output logic [2**ADDR_W-1:0]  busy,
   output logic [ADDR_W:0]       busy_cnt
);

   localparam int unsigned DEPTH = 2**ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;

   logic [DEPTH-1:0] busy_nxt;
   logic [CNT_W-1:0] cnt_nxt;

   // Next busy vector: clears first so a same-cycle set (newer producer) wins; flush beats all.
   always_comb begin
      busy_nxt = busy;
      if (clr_a) busy_nxt[clr_a_addr] = 1'b0;
      if (clr_b) busy_nxt[clr_b_addr] = 1'b0;
      if (set)   busy_nxt[set_addr]   = 1'b1;
      if (flush) busy_nxt = '0;
   end

   // Population count of the next-state vector so busy_cnt tracks busy exactly.
   always_comb begin
      cnt_nxt = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         busy     <= busy_nxt;
         busy_cnt <= cnt_nxt;
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// General-purpose register file with NRD read ports, two prioritised write
// ports, optional zero register, optional write-to-read bypass and a busy
// scoreboard for decode-stage stalls.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   rd_addr/rd_data/rd_busy    packed read ports (combinational data and busy)
//   wa_*                       write port A (ALU writeback, higher priority)
//   wb_*                       write port B (load writeback)
//   iss_en/iss_addr            mark destination register busy
//   flush                      clear all busy bits
//   busy_cnt                   registered number of busy registers
module regfile_sb
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W   = REG_DATA_W,
   parameter int unsigned ADDR_W   = REG_ADDR_W,
   parameter int unsigned NRD      = 2,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NRD*ADDR_W-1:0] rd_addr,
   output logic [NRD*DATA_W-1:0] rd_data,
   output logic [NRD-1:0]        rd_busy,
   input  logic                  wa_en,
   input  logic [ADDR_W-1:0]     wa_addr,
   input  logic [DATA_W-1:0]     wa_data,
   input  logic                  wb_en,
   input  logic [ADDR_W-1:0]     wb_addr,
   input  logic [DATA_W-1:0]     wb_data,
   input  logic                  iss_en,
   input  logic [ADDR_W-1:0]     iss_addr,
   input  logic                  flush,
   output logic [ADDR_W:0]       busy_cnt
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic              wa_we;
   logic              wb_we;
   logic              wb_store;
   logic              iss_we;

   function automatic logic is_zero(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == ADDR_W'(ZERO_ADDR));
   endfunction

   // Effective enables; a low enable masks any X on its address.
   assign wa_we    = wa_en  && !is_zero(wa_addr);
   assign wb_we    = wb_en  && !is_zero(wb_addr);
   assign iss_we   = iss_en && !is_zero(iss_addr);
   assign wb_store = wb_we  && !(wa_we && (wa_addr == wb_addr));

   // Storage array.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (wa_we)    mem[wa_addr] <= wa_data;
         if (wb_store) mem[wb_addr] <= wb_data;
      end
   end

   regfile_sb_scoreboard #(
      .ADDR_W (ADDR_W)
   ) u_sb (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_a      (wa_we),
      .clr_a_addr (wa_addr),
      .clr_b      (wb_we),
      .clr_b_addr (wb_addr),
      .set        (iss_we),
      .set_addr   (iss_addr),
      .flush      (flush),
      .busy       (busy),
      .busy_cnt   (busy_cnt)
   );

   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] val;
   logic              hit_a;
   logic              hit_b;
   logic              bsy;

   // Read muxes: A bypass beats B bypass beats storage; reset and r0 force zero.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      addr    = '0;
      val     = '0;
      hit_a   = 1'b0;
      hit_b   = 1'b0;
      bsy     = 1'b0;
      for (int unsigned k = 0; k < NRD; k++) begin
         addr  = rd_addr[k*ADDR_W +: ADDR_W];
         hit_a = (BYPASS != 0) && wa_we && (wa_addr == addr);
         hit_b = (BYPASS != 0) && wb_we && (wb_addr == addr);
         val   = mem[addr];
         if (hit_a)      val = wa_data;
         else if (hit_b) val = wb_data;
         bsy = busy[addr] && !(hit_a || hit_b);
         if (!rst_n || is_zero(addr)) begin
            val = '0;
            bsy = 1'b0;
         end
         rd_data[k*DATA_W +: DATA_W] = val;
         rd_busy[k]                  = bsy;
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed-vector bench for regfile_sb: default configuration plus a
// NRD=4 / ADDR_W=3 / DATA_W=16 / no-bypass instance.
module tb_regfile_sb;

   logic clk;
   logic rst_n;

   // Default instance signals
   logic [9:0]  rd_addr0;
   logic [63:0] rd_data0;
   logic [1:0]  rd_busy0;
   logic        wa_en0, wb_en0, iss_en0, flush0;
   logic [4:0]  wa_addr0, wb_addr0, iss_addr0;
   logic [31:0] wa_data0, wb_data0;
   logic [5:0]  busy_cnt0;

   // Sweep instance signals
   logic [11:0] rd_addr1;
   logic [63:0] rd_data1;
   logic [3:0]  rd_busy1;
   logic        wa_en1, wb_en1, iss_en1, flush1;
   logic [2:0]  wa_addr1, wb_addr1, iss_addr1;
   logic [15:0] wa_data1, wb_data1;
   logic [3:0]  busy_cnt1;

   int n_chk  = 0;
   int n_pass = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   regfile_sb u0 (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_addr  (rd_addr0),
      .rd_data  (rd_data0),
      .rd_busy  (rd_busy0),
      .wa_en    (wa_en0),
      .wa_addr  (wa_addr0),
      .wa_data  (wa_data0),
      .wb_en    (wb_en0),
      .wb_addr  (wb_addr0),
      .wb_data  (wb_data0),
      .iss_en   (iss_en0),
      .iss_addr (iss_addr0),
      .flush    (flush0),
      .busy_cnt (busy_cnt0)
   );

   regfile_sb #(
      .DATA_W   (16),
      .ADDR_W   (3),
      .NRD      (4),
      .ZERO_REG (1),
      .BYPASS   (0)
   ) u1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_addr  (rd_addr1),
      .rd_data  (rd_data1),
      .rd_busy  (rd_busy1),
      .wa_en    (wa_en1),
      .wa_addr  (wa_addr1),
      .wa_data  (wa_data1),
      .wb_en    (wb_en1),
      .wb_addr  (wb_addr1),
      .wb_data  (wb_data1),
      .iss_en   (iss_en1),
      .iss_addr (iss_addr1),
      .flush    (flush1),
      .busy_cnt (busy_cnt1)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else n_pass++;
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle0();
      wa_en0 = 1'b0; wb_en0 = 1'b0; iss_en0 = 1'b0; flush0 = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      rd_addr0 = '0; wa_addr0 = '0; wb_addr0 = '0; iss_addr0 = '0;
      wa_data0 = '0; wb_data0 = '0;
      idle0();
      rd_addr1 = '0; wa_addr1 = '0; wb_addr1 = '0; iss_addr1 = '0;
      wa_data1 = '0; wb_data1 = '0;
      wa_en1 = 1'b0; wb_en1 = 1'b0; iss_en1 = 1'b0; flush1 = 1'b0;

      #1;
      check("rst_cnt", 64'(busy_cnt0), 64'd0);
      check("rst_data", rd_data0, 64'd0);
      #11 rst_n = 1'b1;
      tick();

      // Same-cycle bypass from port A, then stored value
      wa_en0 = 1'b1; wa_addr0 = 5'd3; wa_data0 = 32'h12345678;
      rd_addr0 = {5'd5, 5'd3};
      #1;
      check("byp_a", 64'(rd_data0[31:0]), 64'h12345678);
      check("byp_other", 64'(rd_data0[63:32]), 64'h0);
      tick();
      idle0();
      #1;
      check("stored_r3", 64'(rd_data0[31:0]), 64'h12345678);

      // A/B conflict on r7: A wins, also when bypassed
      wa_en0 = 1'b1; wa_addr0 = 5'd7; wa_data0 = 32'h1;
      wb_en0 = 1'b1; wb_addr0 = 5'd7; wb_data0 = 32'h2;
      rd_addr0 = {5'd7, 5'd0};
      #1;
      check("conf_byp", 64'(rd_data0[63:32]), 64'h1);
      tick();
      idle0();
      #1;
      check("conf_r7", 64'(rd_data0[63:32]), 64'h1);

      // Port B alone, bypass then stored
      wb_en0 = 1'b1; wb_addr0 = 5'd8; wb_data0 = 32'h2;
      rd_addr0 = {5'd7, 5'd8};
      #1;
      check("byp_b", 64'(rd_data0[31:0]), 64'h2);
      tick();
      idle0();
      #1;
      check("wb_r8", 64'(rd_data0[31:0]), 64'h2);

      // Issue r4 then r9
      iss_en0 = 1'b1; iss_addr0 = 5'd4;
      tick();
      iss_addr0 = 5'd9;
      tick();
      idle0();
      rd_addr0 = {5'd9, 5'd4};
      #1;
      check("sb_cnt2", 64'(busy_cnt0), 64'd2);
      check("sb_busy49", 64'(rd_busy0), 64'b11);

      // Zero register ignores writes and issues
      wa_en0 = 1'b1; wa_addr0 = 5'd0; wa_data0 = 32'hFFFFFFFF;
      iss_en0 = 1'b1; iss_addr0 = 5'd0;
      rd_addr0 = {5'd4, 5'd0};
      #1;
      check("zero_byp", 64'(rd_data0[31:0]), 64'h0);
      check("zero_busy", 64'(rd_busy0[0]), 64'd0);
      tick();
      idle0();
      #1;
      check("zero_data", 64'(rd_data0[31:0]), 64'h0);
      check("zero_cnt", 64'(busy_cnt0), 64'd2);

      // Write and reissue r4 in the same cycle: set wins
      wb_en0 = 1'b1; wb_addr0 = 5'd4; wb_data0 = 32'hCAFE;
      iss_en0 = 1'b1; iss_addr0 = 5'd4;
      rd_addr0 = {5'd9, 5'd4};
      #1;
      check("busy_byp_masked", 64'(rd_busy0), 64'b10);
      tick();
      idle0();
      #1;
      check("setwin_cnt", 64'(busy_cnt0), 64'd2);
      check("setwin_busy", 64'(rd_busy0), 64'b11);

      // Writeback to r9 clears it
      wa_en0 = 1'b1; wa_addr0 = 5'd9; wa_data0 = 32'h99;
      tick();
      idle0();
      #1;
      check("clr_cnt", 64'(busy_cnt0), 64'd1);
      check("clr_busy", 64'(rd_busy0), 64'b01);

      // Reissue of an already-busy register
      iss_en0 = 1'b1; iss_addr0 = 5'd4;
      tick();
      idle0();
      #1;
      check("reiss_cnt", 64'(busy_cnt0), 64'd1);

      // Flush discards same-cycle issue
      flush0 = 1'b1; iss_en0 = 1'b1; iss_addr0 = 5'd10;
      tick();
      idle0();
      rd_addr0 = {5'd10, 5'd4};
      #1;
      check("flush_cnt", 64'(busy_cnt0), 64'd0);
      check("flush_busy", 64'(rd_busy0), 64'b00);
      check("flush_keep", 64'(rd_data0[31:0]), 64'hCAFE);

      // Sweep instance: no bypass, four ports
      wa_en1 = 1'b1; wa_addr1 = 3'd2; wa_data1 = 16'hABCD;
      rd_addr1 = {3'd2, 3'd2, 3'd2, 3'd2};
      #1;
      check("nb_old", rd_data1, 64'h0);
      tick();
      wa_en1 = 1'b0;
      #1;
      check("nb_new", rd_data1, {4{16'hABCD}});
      for (int r = 0; r < 8; r++) begin
         iss_en1 = 1'b1; iss_addr1 = 3'(r);
         tick();
      end
      iss_en1 = 1'b0;
      rd_addr1 = {3'd7, 3'd1, 3'd2, 3'd0};
      #1;
      check("nb_cnt7", 64'(busy_cnt1), 64'd7);
      check("nb_busy", 64'(rd_busy1), 64'b1110);

      // Asynchronous reset mid-run
      wa_en0 = 1'b1; wa_addr0 = 5'd5; wa_data0 = 32'hDEADBEEF;
      iss_en0 = 1'b1; iss_addr0 = 5'd6;
      tick();
      idle0();
      rd_addr0 = {5'd6, 5'd5};
      #1;
      check("pre_rst_r5", 64'(rd_data0[31:0]), 64'hDEADBEEF);
      check("pre_rst_cnt", 64'(busy_cnt0), 64'd1);
      rst_n = 1'b0;
      #1;
      check("async_r5", 64'(rd_data0[31:0]), 64'h0);
      check("async_cnt", 64'(busy_cnt0), 64'd0);
      check("async_busy", 64'(rd_busy0), 64'b00);
      check("async_cnt1", 64'(busy_cnt1), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
